// File: rtl/cvxif_result_arbiter.sv
// rtl/cvxif_result_arbiter.sv - merges two coprocessor result streams into one registered
// CV-X-IF result port, with per-requester FIFOs, round-robin grant and commit-kill squashing.
module cvxif_result_arbiter #(
  parameter int XLEN        = 32,
  parameter int IdWidth     = 4,
  parameter int HartIdWidth = 1,
  parameter int Depth       = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_o,
  input  logic [1:0][HartIdWidth-1:0] req_hartid_i,
  input  logic [1:0][IdWidth-1:0]     req_id_i,
  input  logic [1:0][XLEN-1:0]        req_data_i,
  input  logic [1:0][4:0]             req_rd_i,
  input  logic [1:0]                  req_we_i,
  input  logic                        commit_valid_i,
  input  logic                        commit_kill_i,
  input  logic [IdWidth-1:0]          commit_id_i,
  input  logic [HartIdWidth-1:0]      commit_hartid_i,
  output logic                        result_valid_o,
  input  logic                        result_ready_i,
  output logic [HartIdWidth-1:0]      result_hartid_o,
  output logic [IdWidth-1:0]          result_id_o,
  output logic [XLEN-1:0]             result_data_o,
  output logic [4:0]                  result_rd_o,
  output logic                        result_we_o,
  output logic                        busy_o
);

  localparam int AW = $clog2(Depth);
  localparam int EW = HartIdWidth + IdWidth + XLEN + 5 + 1;

  logic [EW-1:0]          mem [2][Depth];
  logic [1:0][Depth-1:0]  killed, killed_next;
  logic [1:0][AW:0]       wptr, rptr;
  logic                   rr;
  logic                   out_valid;
  logic [EW-1:0]          out_entry;

  logic [1:0] full, empty, head_kill, eligible, push, pop, grant;
  logic       load, kill_cmd;
  logic [AW:0]   cnt;
  logic [AW-1:0] off;

  always_comb begin
    kill_cmd    = commit_valid_i & commit_kill_i;
    full        = '0;
    empty       = '0;
    head_kill   = '0;
    eligible    = '0;
    push        = '0;
    killed_next = killed;
    cnt         = '0;
    off         = '0;
    for (int n = 0; n < 2; n++) begin
      full[n]      = (wptr[n][AW] != rptr[n][AW]) && (wptr[n][AW-1:0] == rptr[n][AW-1:0]);
      empty[n]     = (wptr[n] == rptr[n]);
      head_kill[n] = !empty[n] && killed[n][rptr[n][AW-1:0]];
      eligible[n]  = !empty[n] && !head_kill[n];
      push[n]      = req_valid_i[n] && !full[n];
    end
    load  = !out_valid || result_ready_i;
    grant = 2'b00;
    if (load) begin
      if (&eligible) grant[rr] = 1'b1;
      else           grant = eligible;
    end
    // Killed heads drain on their own without touching the round-robin pointer.
    pop = grant | head_kill;
    for (int n = 0; n < 2; n++) begin
      cnt = wptr[n] - rptr[n];
      for (int i = 0; i < Depth; i++) begin
        off = AW'(i) - rptr[n][AW-1:0];
        if (kill_cmd && ({1'b0, off} < cnt)
            && (mem[n][i][EW-1 -: HartIdWidth] == commit_hartid_i)
            && (mem[n][i][EW-HartIdWidth-1 -: IdWidth] == commit_id_i))
          killed_next[n][i] = 1'b1;
      end
      if (pop[n]) killed_next[n][rptr[n][AW-1:0]] = 1'b0;
      if (push[n])
        killed_next[n][wptr[n][AW-1:0]] = kill_cmd && (req_id_i[n] == commit_id_i)
                                          && (req_hartid_i[n] == commit_hartid_i);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n])
        mem[n][wptr[n][AW-1:0]] <= {req_hartid_i[n], req_id_i[n], req_data_i[n],
                                    req_rd_i[n], req_we_i[n]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr      <= '0;
      rptr      <= '0;
      killed    <= '0;
      rr        <= 1'b0;
      out_valid <= 1'b0;
      out_entry <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        wptr[n] <= wptr[n] + {{AW{1'b0}}, push[n]};
        rptr[n] <= rptr[n] + {{AW{1'b0}}, pop[n]};
      end
      killed <= killed_next;
      if (load) out_valid <= |grant;
      if (|grant) begin
        out_entry <= mem[grant[1]][rptr[grant[1]][AW-1:0]];
        rr        <= grant[0];
      end
    end
  end

  assign req_ready_o    = ~full;
  assign result_valid_o = out_valid;
  assign {result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o} = out_entry;
  assign busy_o         = !(&empty) || out_valid;

endmodule
